// File: rtl/vote_input_conditioner_if.sv
// Raw button/mode inputs and conditioned outputs between the front panel
// and the vote conditioner. The conditioner is the slave side.
interface vote_input_conditioner_if;
   logic mode_in;
   logic button1_in;
   logic button2_in;
   logic button3_in;
   logic button4_in;
   logic mode;
   logic button1;
   logic button2;
   logic button3;
   logic button4;
   logic reject;
   logic busy;

   modport master (
      output mode_in, button1_in, button2_in, button3_in, button4_in,
      input  mode, button1, button2, button3, button4, reject, busy
   );

   modport slave (
      input  mode_in, button1_in, button2_in, button3_in, button4_in,
      output mode, button1, button2, button3, button4, reject, busy
   );
endinterface

// File: rtl/vote_input_conditioner.sv
// Synchronises and debounces the candidate buttons and mode switch.
// In vote mode each accepted single press becomes one single-cycle vote pulse;
// multi-button presses are refused with a reject pulse. In result mode the
// debounced levels are forwarded unchanged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready to accept a new press
// PRESSED | one vote issued, waiting for all buttons to release
// BLOCKED | multi-press refused, waiting for all buttons to release
// HOLDOFF | dead time after release before the next vote is accepted
module vote_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 32
) (
   input  logic clock,
   input  logic reset,
   vote_input_conditioner_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED, HOLDOFF} state_t;

   logic [4:0]    raw;
   logic [4:0]    s1;
   logic [4:0]    s2;
   logic [3:0]    d;
   logic [CW-1:0] cnt [4];
   logic [2:0]    n;
   logic          mode_cur;
   logic          mode_nxt;
   state_t        state;
   state_t        state_nxt;
   logic [HW-1:0] hcnt;
   logic [HW-1:0] hcnt_nxt;
   logic [3:0]    pulse;
   logic [3:0]    pulse_nxt;
   logic          reject_q;
   logic          reject_nxt;

   assign raw = {bus.mode_in, bus.button4_in, bus.button3_in,
                 bus.button2_in, bus.button1_in};

   // Two-flop synchronisers on every raw input.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Per-button debounce: level follows s2 only after it has differed for
   // DEBOUNCE_CYCLES consecutive edges.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s2[i] != d[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  d[i]   <= s2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Number of debounced buttons currently held.
   always_comb begin
      n = 3'(d[0]) + 3'(d[1]) + 3'(d[2]) + 3'(d[3]);
   end

   // mode_nxt is the value the mode register takes on the coming edge, so a
   // mode change governs the FSM on the very edge where mode itself changes.
   assign mode_cur = s2[4];
   assign mode_nxt = s1[4];

   // FSM, hold-off counter and registered pulse outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         hcnt     <= '0;
         pulse    <= '0;
         reject_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         hcnt     <= hcnt_nxt;
         pulse    <= pulse_nxt;
         reject_q <= reject_nxt;
      end
   end

   // Next-state logic; entering vote mode with buttons already held skips
   // the pulse so a press carried across the switch never votes.
   always_comb begin
      state_nxt  = state;
      hcnt_nxt   = hcnt;
      pulse_nxt  = '0;
      reject_nxt = 1'b0;
      if (mode_nxt) begin
         state_nxt = IDLE;
         hcnt_nxt  = '0;
      end else if (mode_cur) begin
         hcnt_nxt = '0;
         if (n == 3'd1)       state_nxt = PRESSED;
         else if (n >= 3'd2)  state_nxt = BLOCKED;
         else                 state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (n == 3'd1) begin
                  state_nxt = PRESSED;
                  pulse_nxt = d;
               end else if (n >= 3'd2) begin
                  state_nxt  = BLOCKED;
                  reject_nxt = 1'b1;
               end
            end
            PRESSED, BLOCKED: begin
               if (n == 3'd0) begin
                  state_nxt = HOLDOFF;
                  hcnt_nxt  = '0;
               end
            end
            HOLDOFF: begin
               if (n != 3'd0) begin
                  hcnt_nxt = '0;
               end else if (hcnt == HOLD_LAST) begin
                  state_nxt = IDLE;
                  hcnt_nxt  = '0;
               end else begin
                  hcnt_nxt = hcnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               hcnt_nxt  = '0;
            end
         endcase
      end
   end

   assign bus.mode    = mode_cur;
   assign bus.button1 = mode_cur ? d[0] : pulse[0];
   assign bus.button2 = mode_cur ? d[1] : pulse[1];
   assign bus.button3 = mode_cur ? d[2] : pulse[2];
   assign bus.button4 = mode_cur ? d[3] : pulse[3];
   assign bus.reject  = reject_q & ~mode_cur;
   assign bus.busy    = (state != IDLE) & ~mode_cur;
endmodule

// File: tb/tb_vote_input_conditioner.sv
// Bench for vote_input_conditioner with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Sample index k is the state after rising edge E_k, where E_0 is the first
// edge that samples the stimulus.
module tb_vote_input_conditioner;
   logic clock;
   logic reset;

   vote_input_conditioner_if bus ();

   vote_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF_CYCLES (3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] mask;
      int         hold;
      logic [3:0] exp_btn;
      int         exp_rej;
      int         exp_first;
      int         exp_busy;
   } vec_t;

   vec_t vecs [8];
   int   errors = 0;
   int   checks = 0;
   int   pulses [4];
   int   rej_cnt;
   int   busy_cnt;
   int   first_evt;
   int   multi;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {bus.mode, bus.button4, bus.button3, bus.button2, bus.button1,
              bus.reject, bus.busy};
   endfunction

   task automatic set_buttons(input logic [3:0] b);
      bus.button1_in = b[0];
      bus.button2_in = b[1];
      bus.button3_in = b[2];
      bus.button4_in = b[3];
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 4; i++) pulses[i] = 0;
      rej_cnt   = 0;
      busy_cnt  = 0;
      first_evt = -1;
      multi     = 0;
   endtask

   task automatic sample(input int k);
      logic [3:0] b;
      b = {bus.button4, bus.button3, bus.button2, bus.button1};
      for (int i = 0; i < 4; i++) if (b[i]) pulses[i]++;
      if (bus.reject) rej_cnt++;
      if (bus.busy) busy_cnt++;
      if ((b != 4'b0 || bus.reject) && first_evt < 0) first_evt = k;
      if (!bus.mode && $countones(b) > 1) multi++;
   endtask

   // Drive for edge E_k, then sample after it. Called at a falling edge.
   task automatic cyc(input logic [3:0] b, input int k);
      set_buttons(b);
      @(posedge clock);
      @(negedge clock);
      sample(k);
   endtask

   task automatic play(input logic [3:0] mask, input int hold, input int win);
      clear_stats();
      for (int k = 0; k < win; k++) cyc((k < hold) ? mask : 4'b0, k);
      set_buttons(4'b0);
   endtask

   task automatic check_stats(input string tag, input logic [3:0] exp_btn,
                              input int exp_rej, input int exp_first,
                              input int exp_busy);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_button%0d_pulses", tag, i + 1), pulses[i],
               exp_btn[i] ? 1 : 0);
      check({tag, "_reject"}, rej_cnt, exp_rej);
      check({tag, "_first_event"}, first_evt, exp_first);
      check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      check({tag, "_multi_hot"}, multi, 0);
   endtask

   initial begin
      vecs[0] = '{4'b0010, 20, 4'b0010, 0,  6, 23};
      vecs[1] = '{4'b1001, 10, 4'b0000, 1,  6, 13};
      vecs[2] = '{4'b1000,  8, 4'b1000, 0,  6, 11};
      vecs[3] = '{4'b0001,  5, 4'b0001, 0,  6,  8};
      vecs[4] = '{4'b0100,  4, 4'b0100, 0,  6,  7};
      vecs[5] = '{4'b0100,  3, 4'b0000, 0, -1,  0};
      vecs[6] = '{4'b0111,  6, 4'b0000, 1,  6,  9};
      vecs[7] = '{4'b1111,  5, 4'b0000, 1,  6,  8};

      // Reset held with every raw input high: all outputs stay 0.
      reset = 1'b0;
      bus.mode_in = 1'b1;
      set_buttons(4'b1111);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("reset_outputs_%0d", k), int'(outs()), 0);
      end

      // Release with button1 held: one vote 6 edges after first sampling.
      bus.mode_in = 1'b0;
      reset = 1'b1;
      play(4'b0001, 10, 24);
      check_stats("after_reset", 4'b0001, 0, 6, 13);

      // Table of single-shot presses.
      for (int i = 0; i < 8; i++) begin
         play(vecs[i].mask, vecs[i].hold, vecs[i].hold + 14);
         check_stats($sformatf("vec%0d", i), vecs[i].exp_btn, vecs[i].exp_rej,
                     vecs[i].exp_first, vecs[i].exp_busy);
      end

      // Bounce: toggle every 2 cycles for 12 cycles, then hold 10 cycles.
      clear_stats();
      for (int k = 0; k < 35; k++) begin
         logic [3:0] b;
         if (k < 12)      b = ((k / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
         else if (k < 22) b = 4'b0100;
         else             b = 4'b0000;
         cyc(b, k);
      end
      check_stats("bounce", 4'b0100, 0, 18, 13);

      // Held-press lockout: button3 joins while button1 is held.
      clear_stats();
      for (int k = 0; k < 30; k++) begin
         logic [3:0] b;
         b = 4'b0;
         if (k <= 14) b[0] = 1'b1;
         if (k >= 8 && k <= 14) b[2] = 1'b1;
         cyc(b, k);
      end
      check_stats("lockout", 4'b0001, 0, 6, 18);

      // A button debouncing high during hold-off restarts it and never votes.
      clear_stats();
      for (int k = 0; k < 32; k++) begin
         logic [3:0] b;
         b = 4'b0;
         if (k <= 9) b[0] = 1'b1;
         if (k >= 12 && k <= 19) b[2] = 1'b1;
         cyc(b, k);
      end
      check_stats("holdoff_extend", 4'b0001, 0, 6, 22);

      // Result mode levels, then switch back to vote while button2 is held.
      clear_stats();
      for (int k = 0; k < 53; k++) begin
         logic [6:0] exp;
         bus.mode_in = (k <= 13);
         set_buttons({2'b0, ((k >= 4 && k <= 19) || (k >= 32 && k <= 39)), 1'b0});
         @(posedge clock);
         @(negedge clock);
         exp = '0;
         exp[6] = (k >= 1 && k <= 14);
         exp[3] = (k >= 9 && k <= 14) || (k == 38);
         exp[0] = (k >= 15 && k <= 28) || (k >= 38 && k <= 48);
         check($sformatf("result_seq_k%0d", k), int'(outs()), int'(exp));
      end
      set_buttons(4'b0);

      // Asynchronous reset while a result-mode level is showing.
      bus.mode_in = 1'b1;
      for (int k = 0; k < 10; k++) cyc(4'b1000, k);
      check("pre_reset_level", int'(outs()), 7'b1100000);
      #2 reset = 1'b0;
      #1 check("async_reset_immediate", int'(outs()), 0);
      @(negedge clock);
      check("async_reset_held", int'(outs()), 0);

      // Button4 still held at release debounces from 0 and votes once.
      bus.mode_in = 1'b0;
      reset = 1'b1;
      play(4'b1000, 10, 24);
      check_stats("reset_mid_press", 4'b1000, 0, 6, 13);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vote_input_conditioner.md
# vote_input_conditioner

Front-end button conditioner placed directly upstream of `votingMachine`. It synchronises and debounces the four raw candidate buttons and the mode switch. In vote mode it converts each accepted press into exactly one single-cycle vote pulse, and rejects simultaneous presses. In result mode it forwards clean debounced levels so the selected candidate's count can be displayed.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced level changes (legal range 2..65535).
- `HOLDOFF_CYCLES`, default 32: dead time after all buttons release before the next vote is accepted (legal range 1..65535).

Ports:
- `clock`, input, 1: single system clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `mode_in`, input, 1: raw mode switch (0 = vote, 1 = result).
- `button1_in`..`button4_in`, input, 1 each: raw candidate buttons, asynchronous and bouncy.
- `mode`, output, 1: synchronised mode, fed to `votingMachine.mode`.
- `button1`..`button4`, output, 1 each: conditioned buttons, fed to `votingMachine.button1..4`.
- `reject`, output, 1: one-cycle pulse when a multi-button press is refused.
- `busy`, output, 1: high whenever a new vote cannot be accepted (FSM not in IDLE).

## Operation
- **Synchronisers**: each raw input passes through a 2-flop synchroniser (`s1` → `s2`).
- **Mode path**: `mode` equals `s2` of `mode_in`. It is not debounced.
- **Debounce, per button**:
  - Registers: debounced level `d` and a counter `cnt`.
  - On each edge where `s2 != d`: if `cnt == DEBOUNCE_CYCLES-1`, then `d <= s2` and `cnt <= 0`; otherwise `cnt++`.
  - On each edge where `s2 == d`: `cnt <= 0`.
  - `cnt` width is clog2(DEBOUNCE_CYCLES). It never wraps.
- **Press classification**: `n` is the number of `d` bits that are high, computed combinationally (0..4).
- **Vote-mode FSM** (`mode` = 0):
  - IDLE: if `n == 1`, go to PRESSED and emit a one-cycle pulse on the matching `buttonX`. If `n >= 2`, go to BLOCKED and pulse `reject`.
  - PRESSED: stay while `n != 0`. When `n == 0`, go to HOLDOFF with the hold-off counter at 0. Extra buttons pressed while in PRESSED are ignored; no reject and no pulse.
  - BLOCKED: stay while `n != 0`. When `n == 0`, go to HOLDOFF.
  - HOLDOFF: count each cycle. After HOLDOFF_CYCLES cycles with `n == 0`, return to IDLE. Any cycle with `n != 0` clears the counter and keeps the FSM in HOLDOFF.
- **Result mode** (`mode` = 1):
  - FSM is forced to IDLE and the hold-off counter is cleared.
  - `buttonX = dX` (levels), `reject = 0`, `busy = 0`.
- **Mode transitions**:
  - A mode change takes effect on the edge where `mode` changes.
  - On a 1→0 transition with any `d` high, the FSM enters PRESSED if `n == 1`, or BLOCKED if `n >= 2`, without emitting a pulse or reject. A button already held across the switch never generates a vote.
- **Invariants**:
  - At most one `buttonX` is high per cycle in vote mode.
  - A vote pulse is never longer than 1 cycle.

## Timing
- **Reset** (`reset` = 0, asynchronous):
  - All synchronisers, `d`, counters and outputs clear to 0 immediately.
  - FSM goes to IDLE.
  - `mode`, `button1..4`, `reject` and `busy` read 0.
- **Reset release** is sampled on the next rising edge.
- **Reset mid-press**:
  - No pulse is emitted during or after reset.
  - A button still held at release must first debounce high (`d` starts at 0). Because `n` then rises from 0 to 1 in IDLE, it yields one vote. This is intentional.
- **Press latency**:
  - Raw input is first sampled at edge E0; `s2` changes at E1.
  - `d` rises at edge E(1+DEBOUNCE_CYCLES).
  - `buttonX` is high for the cycle after edge E(2+DEBOUNCE_CYCLES) and low again after the next edge.
  - With the default parameters the pulse appears 18 edges after sampling.
- **Bounce rejection**: a glitch shorter than DEBOUNCE_CYCLES cycles at `s2` never changes `d`.
- **Release latency**: `d` falls DEBOUNCE_CYCLES+1 edges after the release is sampled. The FSM enters HOLDOFF on the next edge.
- **Minimum spacing**: the minimum gap between two accepted votes is press debounce + hold time + release debounce + HOLDOFF_CYCLES.
- **Simultaneous debounce completion**: if two buttons' `d` bits rise on the same edge, `n == 2` and the press is BLOCKED. The `reject` pulse is one cycle.
- **Mode latency**: 2 edges from `mode_in`.

## Test plan
Use `DEBOUNCE_CYCLES` = 4 and `HOLDOFF_CYCLES` = 3 for all benches.

1. **Reset**: hold `reset` = 0 with all raw inputs high. Required: all outputs 0. After release, `button1_in` held high gives exactly one `button1` pulse, 6 edges after the first sampling edge.
2. **Clean vote**: `button2_in` high for 20 cycles, then low. Required:
   - One `button2` pulse, 1 cycle wide, 6 edges after sampling.
   - `busy` high from the pulse until 3 cycles after `d2` falls.
   - No other outputs toggle.
3. **Bounce**: `button3_in` toggles every 2 cycles for 12 cycles, then stays high. Required: no pulse during the toggling; exactly one `button3` pulse 6 edges after the final rise.
4. **Simultaneous press**: `button1_in` and `button4_in` rise on the same cycle and hold for 10 cycles. Required:
   - `reject` pulses once.
   - No `buttonX` pulse.
   - A later single press of `button4_in`, after release and hold-off, votes normally.
5. **Held-press lockout**: hold `button1_in`, then press `button3_in` while it is still held. Required: only the `button1` pulse; `reject` stays 0. A re-press of `button1_in` during HOLDOFF extends the hold-off and produces no pulse.
6. **Result mode**:
   - `mode_in` = 1, then hold `button2_in` high. Required: `mode` rises 2 edges later; `button2` is high as a level from debounce completion until release; `reject` and `busy` stay 0.
   - Switch to `mode_in` = 0 while still holding `button2_in`. Required: no vote pulse until release, hold-off, and a re-press.
